// File: rtl/thor2023_wb128_responder.sv
// rtl/thor2023_wb128_responder.sv - Wishbone 128-bit load/store responder backed by a line SRAM
// Terminates data-cache LOAD/STORE beats with ack, retry or error after a programmable latency.

package thor2023_wb128_pkg;

    localparam logic [4:0] CMD_NONE        = 5'd0;
    localparam logic [4:0] CMD_DCACHE_LOAD = 5'd1;
    localparam logic [4:0] CMD_STORE       = 5'd2;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [3:0]   pri;
        logic [31:0]  vadr;
        logic [127:0] data1;
        logic [4:0]   cmd;
    } wb_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         rty;
        logic         err;
        logic         stall;
        logic         next;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [3:0]   pri;
        logic [31:0]  adr;
        logic [127:0] dat;
    } wb_cmd_response128_t;

endpackage

module thor2023_wb128_responder
    import thor2023_wb128_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int unsigned LAT   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  wb_cmd_request128_t  wbs_req,
    output wb_cmd_response128_t wbs_resp,
    input  logic                hold_i,
    output logic                busy_o
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 4;
    localparam logic [3:0]  LAT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_TERM
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [15:0]         sel_q, sel_d;
    logic [127:0]        data1_q, data1_d;
    logic [IW-1:0]       idx_q, idx_d;
    wb_cmd_response128_t resp_q, resp_d;

    logic [127:0] mem [DEPTH];
    logic [127:0] rd_word;
    logic [127:0] merged;
    logic         mem_we;

    // 33-bit difference: bit 32 set means vadr is below BASE
    logic [32:0]  diff;
    logic         in_range;
    logic         unused_bits;

    assign diff        = {1'b0, wbs_req.vadr} - {1'b0, BASE};
    assign in_range    = !diff[32] && ({1'b0, diff[31:0]} < SPAN);
    assign unused_bits = ^{wbs_req.cmd, diff[31:4+IW], diff[3:0]};

    assign rd_word = mem[idx_q];

    always_comb begin
        merged = rd_word;
        for (int g = 0; g < 16; g++) begin
            if (sel_q[g]) begin
                merged[8*g +: 8] = data1_q[8*g +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        data1_d = data1_q;
        idx_d   = idx_q;
        resp_d  = resp_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                resp_d.ack = 1'b0;
                resp_d.rty = 1'b0;
                resp_d.err = 1'b0;
                if (wbs_req.cyc && wbs_req.stb) begin
                    we_d       = wbs_req.we;
                    sel_d      = wbs_req.sel;
                    data1_d    = wbs_req.data1;
                    idx_d      = diff[4+IW-1:4];
                    resp_d.cid = wbs_req.cid;
                    resp_d.tid = wbs_req.tid;
                    resp_d.pri = wbs_req.pri;
                    resp_d.adr = {wbs_req.vadr[31:4], 4'h0};
                    if (hold_i) begin
                        resp_d.rty = 1'b1;
                        state_d    = ST_TERM;
                    end else if (!in_range) begin
                        resp_d.err = 1'b1;
                        state_d    = ST_TERM;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // An abandoned write still lands so the initiator's store is never half-lost
                if (!wbs_req.cyc) begin
                    mem_we  = we_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    mem_we     = we_q;
                    resp_d.dat = we_q ? merged : rd_word;
                    resp_d.ack = 1'b1;
                    state_d    = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (!wbs_req.stb) begin
                    resp_d.ack = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_TERM: begin
                resp_d.rty = 1'b0;
                resp_d.err = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        resp_d.stall = (state_d != ST_IDLE);
        resp_d.next  = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            sel_q      <= 16'h0000;
            data1_q    <= '0;
            idx_q      <= '0;
            resp_q     <= '0;
            resp_q.pri <= 4'd7;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            data1_q <= data1_d;
            idx_q   <= idx_d;
            resp_q  <= resp_d;
        end
    end

    // SRAM contents survive reset; mem_we is gated by the reset-cleared state register
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= merged;
        end
    end

    assign wbs_resp = resp_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_thor2023_wb128_responder.sv
// tb/tb_thor2023_wb128_responder.sv - directed self-checking bench for thor2023_wb128_responder

module tb_thor2023_wb128_responder;
    import thor2023_wb128_pkg::*;

    logic                clk;
    logic                rst_i;
    logic                hold_i;
    logic                busy_o;
    wb_cmd_request128_t  req;
    wb_cmd_response128_t resp;

    int vectors;
    int miscompares;

    thor2023_wb128_responder #(
        .DEPTH(1024),
        .BASE (32'h0000_0000),
        .LAT  (2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .wbs_req (req),
        .wbs_resp(resp),
        .hold_i  (hold_i),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] vadr, input logic [15:0] sel,
                         input logic [127:0] data, input logic [7:0] tid);
        req.cyc   = 1'b1;
        req.stb   = 1'b1;
        req.we    = we;
        req.sel   = sel;
        req.vadr  = vadr;
        req.data1 = data;
        req.tid   = tid;
        req.cid   = 4'h5;
        req.pri   = 4'd3;
        req.cmd   = we ? CMD_STORE : CMD_DCACHE_LOAD;
    endtask

    task automatic do_req(input logic we, input logic [31:0] vadr, input logic [15:0] sel,
                          input logic [127:0] data, input logic [7:0] tid,
                          output int lat, output logic [127:0] dat,
                          output logic [7:0] rtid, output logic [31:0] radr);
        drive(we, vadr, sel, data, tid);
        lat  = -1;
        dat  = '0;
        rtid = '0;
        radr = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (resp.ack === 1'b1) begin
                lat  = i;
                dat  = resp.dat;
                rtid = resp.tid;
                radr = resp.adr;
                break;
            end
        end
        req.cyc = 1'b0;
        req.stb = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        vectors++;
        if ({resp.ack, resp.rty, resp.err, resp.stall, resp.next} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {resp.ack, resp.rty, resp.err, resp.stall, resp.next});
        end
        vectors++;
        if (resp.pri !== 4'd7) begin
            miscompares++;
            $display("FAIL reset_pri: got %0d expected 7", resp.pri);
        end
        vectors++;
        if ({resp.cid, resp.tid, resp.adr, resp.dat} !== '0) begin
            miscompares++;
            $display("FAIL reset_fields: tid %h adr %h dat %h expected all 0", resp.tid, resp.adr, resp.dat);
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [127:0] dat;
        logic [7:0]   tid;
        logic [31:0]  adr;
        do_req(1'b1, 32'h40, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, 8'h25, lat, dat, tid, adr);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL wr_latency: got %0d expected 3", lat);
        end
        vectors++;
        if (tid !== 8'h25) begin
            miscompares++;
            $display("FAIL wr_tid: got %h expected 25", tid);
        end
        vectors++;
        if (dat !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL wr_dat: got %h expected 0123456789abcdef0123456789abcdef", dat);
        end
        vectors++;
        if ({resp.ack, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_release: ack/busy got %b expected 00", {resp.ack, busy_o});
        end
        do_req(1'b0, 32'h40, 16'h0000, 128'h0, 8'h26, lat, dat, tid, adr);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL rd_latency: got %0d expected 3", lat);
        end
        vectors++;
        if (dat !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL rd_dat: got %h expected 0123456789abcdef0123456789abcdef", dat);
        end
        vectors++;
        if ({tid, adr} !== {8'h26, 32'h40}) begin
            miscompares++;
            $display("FAIL rd_id: tid %h adr %h expected 26 00000040", tid, adr);
        end
    endtask

    task automatic test_byte_lane();
        int lat;
        logic [127:0] dat;
        logic [7:0]   tid;
        logic [31:0]  adr;
        do_req(1'b1, 32'h80, 16'hFFFF, 128'h0, 8'h01, lat, dat, tid, adr);
        do_req(1'b1, 32'h80, 16'h00F0, {16{8'hAA}}, 8'h02, lat, dat, tid, adr);
        vectors++;
        if (dat !== 128'h00000000_00000000_AAAAAAAA_00000000) begin
            miscompares++;
            $display("FAIL lane_wr_dat: got %h expected 0000000000000000aaaaaaaa00000000", dat);
        end
        // sel of zero: acked, memory unchanged
        do_req(1'b1, 32'h88, 16'h0000, {16{8'h55}}, 8'h03, lat, dat, tid, adr);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL lane_sel0_ack: got %0d expected 3", lat);
        end
        do_req(1'b0, 32'h8C, 16'h0000, 128'h0, 8'h04, lat, dat, tid, adr);
        vectors++;
        if (dat !== 128'h00000000_00000000_AAAAAAAA_00000000) begin
            miscompares++;
            $display("FAIL lane_rd_dat: got %h expected 0000000000000000aaaaaaaa00000000", dat);
        end
        vectors++;
        if (adr !== 32'h80) begin
            miscompares++;
            $display("FAIL lane_rd_adr: got %h expected 00000080", adr);
        end
    endtask

    task automatic test_range_error();
        int lat;
        logic [127:0] dat;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic         seen_ack;
        drive(1'b0, 32'h4000, 16'h0000, 128'h0, 8'h31);
        tick();
        req.cyc = 1'b0;
        req.stb = 1'b0;
        vectors++;
        if ({resp.err, resp.rty, resp.ack, resp.tid} !== {3'b100, 8'h31}) begin
            miscompares++;
            $display("FAIL err_pulse: err/rty/ack %b tid %h expected 100 31",
                     {resp.err, resp.rty, resp.ack}, resp.tid);
        end
        seen_ack = 1'b0;
        tick();
        vectors++;
        if ({resp.err, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL err_clear: err/busy got %b expected 00", {resp.err, busy_o});
        end
        for (int i = 0; i < 4; i++) begin
            if (resp.ack !== 1'b0) seen_ack = 1'b1;
            tick();
        end
        vectors++;
        if (seen_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL err_no_ack: got ack 1 expected 0");
        end
        do_req(1'b0, 32'h3FF0, 16'h0000, 128'h0, 8'h32, lat, dat, tid, adr);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL top_word_ack: got %0d expected 3", lat);
        end
    endtask

    task automatic test_retry();
        int lat;
        logic [127:0] dat;
        logic [7:0]   tid;
        logic [31:0]  adr;
        hold_i = 1'b1;
        drive(1'b0, 32'h40, 16'h0000, 128'h0, 8'h41);
        tick();
        hold_i = 1'b0;
        vectors++;
        if ({resp.rty, resp.err, resp.ack, resp.tid} !== {3'b100, 8'h41}) begin
            miscompares++;
            $display("FAIL rty_pulse: rty/err/ack %b tid %h expected 100 41",
                     {resp.rty, resp.err, resp.ack}, resp.tid);
        end
        tick();
        vectors++;
        if ({resp.rty, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL rty_clear: rty/busy got %b expected 00", {resp.rty, busy_o});
        end
        do_req(1'b0, 32'h40, 16'h0000, 128'h0, 8'h41, lat, dat, tid, adr);
        vectors++;
        if (lat !== 3 || dat !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
            miscompares++;
            $display("FAIL rty_reaccept: lat %0d dat %h expected 3 0123456789abcdef0123456789abcdef", lat, dat);
        end
    endtask

    task automatic test_ack_hold_abandon();
        int lat;
        logic [127:0] dat;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic         held;
        logic         seen_ack;
        drive(1'b1, 32'h180, 16'hFFFF, 128'hCAFEF00D_11223344_55667788_99AABBCC, 8'h51);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (resp.ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        held = 1'b1;
        req.data1 = 128'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp.ack !== 1'b1 || busy_o !== 1'b1) held = 1'b0;
        end
        vectors++;
        if (lat !== 3 || held !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_hold: lat %0d held %b expected 3 1", lat, held);
        end
        req.cyc = 1'b0;
        req.stb = 1'b0;
        tick();
        vectors++;
        if (resp.ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_drop: got %b expected 0", resp.ack);
        end
        do_req(1'b0, 32'h180, 16'h0000, 128'h0, 8'h52, lat, dat, tid, adr);
        vectors++;
        if (dat !== 128'hCAFEF00D_11223344_55667788_99AABBCC) begin
            miscompares++;
            $display("FAIL ack_hold_mem: got %h expected cafef00d112233445566778899aabbcc", dat);
        end

        do_req(1'b1, 32'h100, 16'hFFFF, 128'h0, 8'h53, lat, dat, tid, adr);
        drive(1'b1, 32'h100, 16'hFFFF, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 8'h54);
        tick();
        req.cyc = 1'b0;
        req.stb = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp.ack !== 1'b0) seen_ack = 1'b1;
        end
        vectors++;
        if ({seen_ack, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL abandon_no_ack: ack/busy got %b expected 00", {seen_ack, busy_o});
        end
        do_req(1'b0, 32'h100, 16'h0000, 128'h0, 8'h55, lat, dat, tid, adr);
        vectors++;
        if (dat !== 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF) begin
            miscompares++;
            $display("FAIL abandon_write: got %h expected deadbeefdeadbeefdeadbeefdeadbeef", dat);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] dat;
        logic [7:0]   tid;
        logic [31:0]  adr;
        do_req(1'b1, 32'h140, 16'hFFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'h61, lat, dat, tid, adr);
        drive(1'b1, 32'h140, 16'hFFFF, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 8'h62);
        tick();
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        vectors++;
        if ({resp.ack, resp.stall, busy_o, resp.pri, resp.tid} !== {3'b000, 4'd7, 8'h00}) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: ack/stall/busy %b pri %0d tid %h expected 000 7 00",
                     {resp.ack, resp.stall, busy_o}, resp.pri, resp.tid);
        end
        req.cyc = 1'b0;
        req.stb = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        do_req(1'b0, 32'h140, 16'h0000, 128'h0, 8'h63, lat, dat, tid, adr);
        vectors++;
        if (lat !== 3 || dat !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin
            miscompares++;
            $display("FAIL rst_mid_mem: lat %0d dat %h expected 3 11112222333344445555666677778888", lat, dat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] dat;
        logic [7:0]   tid;
        logic [31:0]  adr;
        do_req(1'b0, 32'h80, 16'h0000, 128'h0, 8'h71, lat, dat, tid, adr);
        do_req(1'b0, 32'h180, 16'h0000, 128'h0, 8'h72, lat, dat, tid, adr);
        vectors++;
        if ({lat, tid} !== {32'd3, 8'h72}) begin
            miscompares++;
            $display("FAIL b2b_second: lat %0d tid %h expected 3 72", lat, tid);
        end
        vectors++;
        if (resp.pri !== 4'd3 || resp.cid !== 4'h5) begin
            miscompares++;
            $display("FAIL b2b_echo: pri %0d cid %h expected 3 5", resp.pri, resp.cid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_i       = 1'b0;
        hold_i      = 1'b0;
        req         = '0;
        tick();
        tick();
        test_reset();
        rst_i = 1'b1;
        tick();
        test_write_read();
        test_byte_lane();
        test_range_error();
        test_retry();
        test_ack_hold_abandon();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
